kuznechik_key_sched: RTL and testbench

Controller that sequences the Kuznechik key generator and stores its results as a round-key file. It accepts a 256-bit master key through a valid/ready handshake and holds the generator in reset with that key applied. It then enables the generator and captures its five key-pair pulses into a 10×128-bit store, after which it serves round keys K1..K10 to the cipher datapath by index. It sits between the host/config interface and the encrypt/decrypt round pipeline, and watches the generator for protocol errors and hangs.

---
 rtl/kuznechik_key_sched.sv | 140 ++++++++++++++
 tb/tb_kuznechik_key_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kuznechik_key_sched.sv
// Kuznechik key-schedule controller: loads a 256-bit master key, runs the
// external key generator, captures its five key pairs into a 10 x 128-bit
// round-key store and serves the round keys K1..K10 by index.
module kuznechik_key_sched #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_valid,
   input  logic [255:0] master_key,
   output logic         load_ready,
   output logic         kg_rst_n,
   output logic         kg_en,
   output logic [255:0] kg_master_key,
   input  logic [255:0] kg_round_keys,
   input  logic         kg_ready,
   input  logic         kg_full_ready,
   input  logic         rk_rd_en,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_data,
   output logic         rk_data_valid,
   output logic         keys_valid,
   output logic         busy,
   output logic         error
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state, state_next;
   logic [2:0]       pair_cnt, pair_cnt_next;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_next;
   logic             accept;
   logic             capture;
   logic [3:0]       even_idx;
   logic [3:0]       odd_idx;
   logic [127:0]     key_store [10];

   // State-decoded outputs and the load handshake
   always_comb begin
      load_ready = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
      kg_rst_n   = (state == S_RUN);
      kg_en      = (state == S_RUN);
      busy       = (state == S_LOAD) || (state == S_RUN);
      keys_valid = (state == S_DONE);
      error      = (state == S_ERR);
      accept     = load_valid && load_ready;
      even_idx   = {pair_cnt, 1'b0};
      odd_idx    = {pair_cnt, 1'b1};
   end

   // Next-state, pair capture and timeout evaluation
   always_comb begin
      state_next    = state;
      pair_cnt_next = pair_cnt;
      tmo_cnt_next  = tmo_cnt;
      capture       = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (accept) begin
               state_next    = S_LOAD;
               pair_cnt_next = '0;
               tmo_cnt_next  = '0;
            end
         end
         S_LOAD: begin
            state_next = S_RUN;
         end
         S_RUN: begin
            tmo_cnt_next = tmo_cnt + 1'b1;
            if (kg_ready && (pair_cnt >= 3'd5)) begin
               state_next = S_ERR;
            end else begin
               if (kg_ready) begin
                  capture       = 1'b1;
                  pair_cnt_next = pair_cnt + 3'd1;
               end
               // completion judges the count including this cycle's capture
               if (kg_full_ready) begin
                  state_next = (pair_cnt_next == 3'd5) ? S_DONE : S_ERR;
               end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  state_next = S_ERR;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Control state, counters and the registered generator key
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         pair_cnt      <= '0;
         tmo_cnt       <= '0;
         kg_master_key <= '0;
      end else begin
         state    <= state_next;
         pair_cnt <= pair_cnt_next;
         tmo_cnt  <= tmo_cnt_next;
         if (accept) begin
            kg_master_key <= master_key;
         end
      end
   end

   // Round-key store; intentionally not cleared, keys_valid gates all reads
   always_ff @(posedge clk) begin
      if (rst_n && capture) begin
         key_store[even_idx] <= kg_round_keys[255:128];
         key_store[odd_idx]  <= kg_round_keys[127:0];
      end
   end

   // Registered read port; data holds when no read is issued
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rk_data       <= '0;
         rk_data_valid <= 1'b0;
      end else if (rk_rd_en) begin
         if (keys_valid && !accept && (rk_idx <= 4'd9)) begin
            rk_data       <= key_store[rk_idx];
            rk_data_valid <= 1'b1;
         end else begin
            rk_data       <= '0;
            rk_data_valid <= 1'b0;
         end
      end else begin
         rk_data_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kuznechik_key_sched.sv
// Directed self-checking bench for kuznechik_key_sched with a behavioural
// generator stand-in that replays the GOST R 34.12-2015 round keys.
module tb_kuznechik_key_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load_valid;
   logic [255:0] master_key;
   logic         load_ready;
   logic         kg_rst_n;
   logic         kg_en;
   logic [255:0] kg_master_key;
   logic [255:0] kg_round_keys;
   logic         kg_ready;
   logic         kg_full_ready;
   logic         rk_rd_en;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         rk_data_valid;
   logic         keys_valid;
   logic         busy;
   logic         error;

   int n_cmp = 0;
   int n_mis = 0;

   logic [255:0] pairs [5];
   logic [255:0] gost_key;
   logic [255:0] key2;

   kuznechik_key_sched #(.TIMEOUT(64)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_valid    (load_valid),
      .master_key    (master_key),
      .load_ready    (load_ready),
      .kg_rst_n      (kg_rst_n),
      .kg_en         (kg_en),
      .kg_master_key (kg_master_key),
      .kg_round_keys (kg_round_keys),
      .kg_ready      (kg_ready),
      .kg_full_ready (kg_full_ready),
      .rk_rd_en      (rk_rd_en),
      .rk_idx        (rk_idx),
      .rk_data       (rk_data),
      .rk_data_valid (rk_data_valid),
      .keys_valid    (keys_valid),
      .busy          (busy),
      .error         (error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [255:0] k);
      load_valid = 1'b1;
      master_key = k;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] idx, input logic exp_v, input logic [127:0] exp_d, input string tag);
      rk_rd_en = 1'b1;
      rk_idx   = idx;
      tick();
      rk_rd_en = 1'b0;
      chk({tag, "_valid"}, 256'(rk_data_valid), 256'(exp_v));
      chk({tag, "_data"}, 256'(rk_data), 256'(exp_d));
   endtask

   // Emit n key-pair pulses, one idle cycle between them; optionally raise
   // kg_full_ready together with the last pulse. Returns just after the last edge.
   task automatic gen(input int start, input int n, input bit full_last);
      for (int i = 0; i < n; i++) begin
         if (i > 0) tick();
         kg_ready      = 1'b1;
         kg_round_keys = pairs[(start + i) % 5];
         kg_full_ready = full_last && (i == n - 1);
         tick();
         kg_ready      = 1'b0;
         kg_full_ready = 1'b0;
         kg_round_keys = '0;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_kg_rst_n"},      256'(kg_rst_n),      256'(0));
      chk({tag, "_kg_en"},         256'(kg_en),         256'(0));
      chk({tag, "_kg_master_key"}, kg_master_key,       256'(0));
      chk({tag, "_keys_valid"},    256'(keys_valid),    256'(0));
      chk({tag, "_busy"},          256'(busy),          256'(0));
      chk({tag, "_error"},         256'(error),         256'(0));
      chk({tag, "_rk_data"},       256'(rk_data),       256'(0));
      chk({tag, "_rk_data_valid"}, 256'(rk_data_valid), 256'(0));
      chk({tag, "_load_ready"},    256'(load_ready),    256'(1));
   endtask

   initial begin
      gost_key = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
      key2     = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0_00112233445566778899aabbccddeeff;
      pairs[0] = gost_key;
      pairs[1] = {128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04};
      pairs[2] = {128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b};
      pairs[3] = {128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984};
      pairs[4] = {128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043};

      rst_n         = 1'b0;
      load_valid    = 1'b0;
      master_key    = '0;
      kg_round_keys = '0;
      kg_ready      = 1'b0;
      kg_full_ready = 1'b0;
      rk_rd_en      = 1'b0;
      rk_idx        = '0;
      tick_n(2);
      rst_n = 1'b1;
      chk_reset_outputs("reset");

      // GOST vector: load, run, read during RUN, simultaneous 5th pulse + full
      do_load(gost_key);
      chk("load_busy",       256'(busy),       256'(1));
      chk("load_ready_low",  256'(load_ready), 256'(0));
      chk("load_kg_key",     kg_master_key,    gost_key);
      chk("load_kg_rst_n",   256'(kg_rst_n),   256'(0));
      tick();
      chk("run_kg_rst_n",    256'(kg_rst_n),   256'(1));
      chk("run_kg_en",       256'(kg_en),      256'(1));
      gen(0, 2, 1'b0);
      tick();
      rd(4'd0, 1'b0, 128'h0, "rd_in_run");
      gen(2, 3, 1'b1);
      chk("done_keys_valid", 256'(keys_valid), 256'(1));
      chk("done_busy",       256'(busy),       256'(0));
      chk("done_load_ready", 256'(load_ready), 256'(1));
      chk("done_kg_rst_n",   256'(kg_rst_n),   256'(0));
      chk("done_kg_en",      256'(kg_en),      256'(0));
      chk("done_error",      256'(error),      256'(0));
      rd(4'd0,  1'b1, 128'h8899aabbccddeeff0011223344556677, "rd_k1");
      rd(4'd2,  1'b1, 128'hdb31485315694343228d6aef8cc78c44, "rd_k3");
      rd(4'd9,  1'b1, 128'h72e9dd7416bcf45b755dbaa88e4a4043, "rd_k10");
      rd(4'd10, 1'b0, 128'h0, "rd_idx10");
      rd(4'd15, 1'b0, 128'h0, "rd_idx15");

      // back-to-back reads, then hold with strobe low
      rk_rd_en = 1'b1;
      rk_idx   = 4'd9;
      tick();
      rk_idx   = 4'd1;
      chk("b2b_0_valid", 256'(rk_data_valid), 256'(1));
      chk("b2b_0_data",  256'(rk_data), 256'(128'h72e9dd7416bcf45b755dbaa88e4a4043));
      tick();
      rk_rd_en = 1'b0;
      chk("b2b_1_valid", 256'(rk_data_valid), 256'(1));
      chk("b2b_1_data",  256'(rk_data), 256'(128'hfedcba98765432100123456789abcdef));
      tick();
      chk("hold_valid",  256'(rk_data_valid), 256'(0));
      chk("hold_data",   256'(rk_data), 256'(128'hfedcba98765432100123456789abcdef));

      // early kg_full_ready after 3 pairs
      do_load(gost_key);
      tick();
      gen(0, 3, 1'b1);
      chk("early_error",      256'(error),      256'(1));
      chk("early_load_ready", 256'(load_ready), 256'(1));
      chk("early_busy",       256'(busy),       256'(0));
      chk("early_kg_en",      256'(kg_en),      256'(0));
      chk("early_keys_valid", 256'(keys_valid), 256'(0));
      rd(4'd0, 1'b0, 128'h0, "rd_in_err");
      do_load(gost_key);
      chk("reload_err_clear", 256'(error), 256'(0));
      chk("reload_err_busy",  256'(busy),  256'(1));

      // sixth kg_ready pulse
      tick();
      gen(0, 5, 1'b0);
      chk("five_no_full_busy", 256'(busy), 256'(1));
      tick();
      gen(0, 1, 1'b0);
      chk("sixth_error", 256'(error), 256'(1));
      chk("sixth_busy",  256'(busy),  256'(0));

      // timeout: error exactly 64 cycles after RUN entry
      do_load(gost_key);
      tick();
      tick_n(63);
      chk("tmo_before_error", 256'(error), 256'(0));
      chk("tmo_before_busy",  256'(busy),  256'(1));
      tick();
      chk("tmo_error",        256'(error), 256'(1));
      chk("tmo_kg_en",        256'(kg_en), 256'(0));

      // reset pulse mid-RUN after two pairs, then a fresh load
      do_load(gost_key);
      tick();
      gen(0, 2, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_outputs("midrun_reset");
      do_load(gost_key);
      tick();
      gen(0, 5, 1'b0);
      tick();
      kg_full_ready = 1'b1;
      tick();
      kg_full_ready = 1'b0;
      chk("fresh_keys_valid", 256'(keys_valid), 256'(1));
      rd(4'd9, 1'b1, 128'h72e9dd7416bcf45b755dbaa88e4a4043, "fresh_rd_k10");

      // reload from DONE with a second key; read issued with the handshake
      pairs[0] = key2;
      for (int i = 1; i < 5; i++) pairs[i] = {128'(2 * i), 128'(2 * i + 1)};
      load_valid = 1'b1;
      master_key = key2;
      rk_rd_en   = 1'b1;
      rk_idx     = 4'd0;
      tick();
      load_valid = 1'b0;
      rk_rd_en   = 1'b0;
      chk("reload_rd_valid",   256'(rk_data_valid), 256'(0));
      chk("reload_keys_valid", 256'(keys_valid),    256'(0));
      chk("reload_busy",       256'(busy),          256'(1));
      chk("reload_kg_key",     kg_master_key,       key2);
      tick();
      gen(0, 5, 1'b1);
      chk("reload_done", 256'(keys_valid), 256'(1));
      rd(4'd0, 1'b1, key2[255:128], "reload_rd_k1");
      rd(4'd3, 1'b1, 128'h3, "reload_rd_k4");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
